axi_4_mst: RTL and testbench

AXI_4_MST -- requirements
Module: axi_4_mst

---
 rtl/axi_4_mst.sv | 174 +++++++++++++++++
 tb/tb_axi_4_mst.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_4_mst.sv
// AXI4-Lite master with one transaction in flight: a user command becomes one
// AXI write (AW+W, then B) or read (AR, then R), and the slave's reply is returned on rsp_*.
module axi_4_mst #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH     = 4
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESET,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic                            cmd_write,
  input  logic [C_ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [C_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic                            rsp_write,
  output logic [C_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                      rsp_resp,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  input  logic [1:0]                      M_AXI_BRESP,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  output logic [C_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic [2:0]                      M_AXI_ARPROT,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                        state_q, state_d;
  logic [C_ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [C_AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]             wstrb_q, wstrb_d;
  logic                          awvalid_q, awvalid_d;
  logic                          wvalid_q, wvalid_d;
  logic                          arvalid_q, arvalid_d;
  logic                          rsp_write_q, rsp_write_d;
  logic [C_AXI_DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic [1:0]                    rsp_resp_q, rsp_resp_d;
  logic                          aw_done, w_done;

  always_ff @(posedge M_AXI_ACLK or posedge M_AXI_ARESET) begin
    if (M_AXI_ARESET) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;
    // A channel counts as done once its VALID has dropped or is being accepted now.
    aw_done     = !awvalid_q || M_AXI_AWREADY;
    w_done      = !wvalid_q  || M_AXI_WREADY;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_REQ;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (aw_done && w_done)          state_d   = WR_RESP;
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          rsp_resp_d  = M_AXI_BRESP;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rsp_resp_d  = M_AXI_RRESP;
          rsp_write_d = 1'b0;
          rsp_rdata_d = M_AXI_RDATA;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Gating with reset keeps cmd_ready low while reset is held, high right after release.
  assign cmd_ready     = (state_q == IDLE) && !M_AXI_ARESET;
  assign rsp_valid     = (state_q == RESP);
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;

  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule

// File: tb/tb_axi_4_mst.sv
// Bench for axi_4_mst: delay-configurable AXI slave model, queue-based response
// scoreboard, directed corner cases and randomized transactions.
`timescale 1ns/1ps
module tb_axi_4_mst;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic rsp_valid, rsp_ready = 1'b0, rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0] rsp_resp;
  logic awvalid, awready = 1'b0, wvalid, wready = 1'b0, bvalid = 1'b0, bready;
  logic arvalid, arready = 1'b0, rvalid = 1'b0, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic [DW-1:0] wdata, rdata = '0;
  logic [SW-1:0] wstrb;
  logic [1:0] bresp = 2'b00, rresp = 2'b00;

  axi_4_mst #(.C_AXI_DATA_WIDTH(DW), .C_ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready), .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_BRESP(bresp),
    .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready), .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          wr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    int            acc;
    int            lat;
  } exp_t;
  exp_t exp_q[$];

  int total = 0, bad = 0, n_rsp = 0, hs_edge = 0, rsp_hold = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Slave model: configurable READY/VALID wait cycles and response contents.
  int cfg_aw = 0, cfg_w = 0, cfg_b = 0, cfg_ar = 0, cfg_r = 0;
  logic [1:0] cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [DW-1:0] cfg_rdata = '0;
  bit aw_fire = 0, w_fire = 0, b_fire = 0, ar_fire = 0, r_fire = 0;
  bit aw_done_s = 0, w_done_s = 0, b_done_s = 1, ar_done_s = 0, r_done_s = 1;
  bit prev_aw = 0, prev_ar = 0, early_b = 0, early_r = 0, unstable_w = 0, unstable_r = 0;
  int aw_hi = 0, w_hi = 0, ar_hi = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  logic [AW-1:0] cap_awaddr = '0, cap_araddr = '0, first_awaddr = '0, first_araddr = '0;
  logic [DW-1:0] cap_wdata = '0, first_wdata = '0;
  logic [SW-1:0] cap_wstrb = '0, first_wstrb = '0;

  initial begin
    forever begin
      tick();
      if (rst) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        prev_aw = 0; prev_ar = 0; b_done_s = 1; r_done_s = 1;
        aw_done_s = 0; w_done_s = 0; ar_done_s = 0;
        continue;
      end
      if (aw_fire) begin awready = 0; aw_done_s = 1; end
      if (w_fire)  begin wready = 0;  w_done_s = 1;  end
      if (b_fire)  begin bvalid = 0;  b_done_s = 1;  end
      if (ar_fire) begin arready = 0; ar_done_s = 1; end
      if (r_fire)  begin rvalid = 0;  r_done_s = 1;  end
      if (awvalid && !prev_aw) begin
        aw_done_s = 0; w_done_s = 0; b_done_s = 0; aw_hi = 0; w_hi = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; early_b = 0; unstable_w = 0;
        first_awaddr = awaddr; first_wdata = wdata; first_wstrb = wstrb;
      end
      if (arvalid && !prev_ar) begin
        ar_done_s = 0; r_done_s = 0; ar_hi = 0; ar_cnt = 0; r_cnt = 0;
        early_r = 0; unstable_r = 0; first_araddr = araddr;
      end
      prev_aw = awvalid;
      prev_ar = arvalid;
      if (awvalid) begin
        aw_hi++;
        if (awaddr !== first_awaddr) unstable_w = 1;
        if (aw_cnt >= cfg_aw) awready = 1; else aw_cnt++;
      end
      if (wvalid) begin
        w_hi++;
        if (wdata !== first_wdata || wstrb !== first_wstrb) unstable_w = 1;
        if (w_cnt >= cfg_w) wready = 1; else w_cnt++;
      end
      if (bready && !(aw_done_s && w_done_s)) early_b = 1;
      if (aw_done_s && w_done_s && !b_done_s && !bvalid) begin
        if (b_cnt >= cfg_b) begin bvalid = 1; bresp = cfg_bresp; end else b_cnt++;
      end
      if (arvalid) begin
        ar_hi++;
        if (araddr !== first_araddr) unstable_r = 1;
        if (ar_cnt >= cfg_ar) arready = 1; else ar_cnt++;
      end
      if (rready && !ar_done_s) early_r = 1;
      if (ar_done_s && !r_done_s && !rvalid) begin
        if (r_cnt >= cfg_r) begin rvalid = 1; rdata = cfg_rdata; rresp = cfg_rresp; end else r_cnt++;
      end
      aw_fire = awvalid && awready;
      w_fire  = wvalid && wready;
      b_fire  = bvalid && bready;
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      if (aw_fire) cap_awaddr = awaddr;
      if (w_fire) begin cap_wdata = wdata; cap_wstrb = wstrb; end
      if (ar_fire) cap_araddr = araddr;
    end
  end

  // Response monitor: pops the scoreboard on each new rsp_valid and drives rsp_ready.
  initial begin
    exp_t e;
    bit prev_rv = 0, prev_hs = 0;
    int hold_cnt = 0;
    logic [DW+2:0] saved = '0;
    forever begin
      tick();
      if (rst) begin
        rsp_ready = 0; prev_rv = 0; prev_hs = 0; hold_cnt = 0;
        continue;
      end
      if (prev_hs) n_rsp++;
      if (rsp_valid) begin
        if (!prev_rv) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rsp", 64'(exp_q.size()), 64'd1);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_write", rsp_write, e.wr);
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", rsp_resp, e.resp);
            if (e.lat >= 0) chk("latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          saved = {rsp_write, rsp_resp, rsp_rdata};
        end else begin
          chk("rsp_stable", {rsp_write, rsp_resp, rsp_rdata}, saved);
        end
        chk("cmd_ready_during_rsp", cmd_ready, 1'b0);
        if (hold_cnt >= rsp_hold) rsp_ready = 1;
        else begin rsp_ready = 0; hold_cnt++; end
      end else begin
        rsp_ready = 0;
        hold_cnt = 0;
      end
      prev_hs = rsp_valid && rsp_ready;
      if (prev_hs) hs_edge = cyc + 1;
      prev_rv = rsp_valid;
    end
  end

  task automatic send_cmd(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input int lat, input bit keep, output int acc);
    exp_t e;
    int n;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    n = 0;
    while (!cmd_ready && n < 300) begin tick(); n++; end
    chk("cmd_accept", cmd_ready, 1'b1);
    acc = cyc + 1;
    e.wr = wr;
    e.rdata = wr ? '0 : cfg_rdata;
    e.resp = wr ? cfg_bresp : cfg_rresp;
    e.acc = acc;
    e.lat = lat;
    exp_q.push_back(e);
    tick();
    if (!keep) cmd_valid = 0;
  endtask

  task automatic wait_rsp(input int tgt);
    int n;
    n = 0;
    while (n_rsp < tgt && n < 300) begin tick(); n++; end
    chk("rsp_count", 64'(n_rsp), 64'(tgt));
  endtask

  task automatic check_slave(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s, input int daw, input int dw, input int dar);
    if (wr) begin
      chk("aw_addr", cap_awaddr, a);
      chk("w_data", cap_wdata, d);
      chk("w_strb", cap_wstrb, s);
      chk("aw_hold", 64'(aw_hi), 64'(daw + 1));
      chk("w_hold", 64'(w_hi), 64'(dw + 1));
      chk("bready_early", early_b, 1'b0);
      chk("aw_w_stable", unstable_w, 1'b0);
    end else begin
      chk("ar_addr", cap_araddr, a);
      chk("ar_hold", 64'(ar_hi), 64'(dar + 1));
      chk("rready_early", early_r, 1'b0);
      chk("ar_stable", unstable_r, 1'b0);
    end
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s, input int daw, input int dw, input int db,
                         input int dar, input int dr, input logic [1:0] rsp,
                         input logic [DW-1:0] rd, input int hold);
    int acc, tgt, lat;
    cfg_aw = daw; cfg_w = dw; cfg_b = db; cfg_ar = dar; cfg_r = dr;
    cfg_bresp = rsp; cfg_rresp = rsp; cfg_rdata = rd; rsp_hold = hold;
    lat = (daw == 0 && dw == 0 && db == 0 && dar == 0 && dr == 0) ? 2 : -1;
    tgt = n_rsp + 1;
    send_cmd(wr, a, d, s, lat, 1'b0, acc);
    wait_rsp(tgt);
    check_slave(wr, a, d, s, daw, dw, dar);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc1, acc2, base, n, tgt;
    logic [AW-1:0] ra;
    logic [DW-1:0] rdv, rrd;
    logic [SW-1:0] rs;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_write, cmd_ready}, 8'h00);
    chk("rst_rsp", {rsp_resp, rsp_rdata}, '0);
    chk("rst_regs", {awaddr, wdata, wstrb, araddr}, '0);
    chk("prot", {awprot, arprot}, 6'b0);
    rst = 0;
    #1;
    chk("cmd_ready_after_rst", cmd_ready, 1'b1);
    tick();

    // Directed cases
    run_txn(1, 4'h3, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
    run_txn(1, 4'h9, 32'hCAFE0001, 4'h5, 3, 0, 0, 0, 0, 2'b01, 32'h0, 0);
    run_txn(1, 4'hC, 32'h0000F00D, 4'h2, 0, 2, 1, 0, 0, 2'b11, 32'h0, 1);
    run_txn(0, 4'h5, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'h12345678, 0);
    run_txn(0, 4'h7, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b10, 32'h0BADF00D, 5);

    // Back-to-back write then read with cmd_valid held
    cfg_aw = 0; cfg_w = 0; cfg_b = 0; cfg_ar = 0; cfg_r = 0; rsp_hold = 0;
    cfg_bresp = 2'b00; cfg_rresp = 2'b01; cfg_rdata = 32'h0F0F1234;
    tgt = n_rsp + 2;
    send_cmd(1, 4'hA, 32'h11112222, 4'h3, 2, 1'b1, acc1);
    send_cmd(0, 4'hB, 32'h0, 4'h0, 2, 1'b0, acc2);
    chk("b2b_accept_edge", 64'(acc2), 64'(hs_edge + 1));
    wait_rsp(tgt);
    check_slave(1, 4'hA, 32'h11112222, 4'h3, 0, 0, 0);
    check_slave(0, 4'hB, 32'h0, 4'h0, 0, 0, 0);

    // Reset while AWVALID/WVALID are high
    cfg_aw = 10; cfg_w = 10;
    base = n_rsp;
    send_cmd(1, 4'h6, 32'h55AA55AA, 4'hF, -1, 1'b0, acc1);
    tick();
    chk("aw_w_before_rst", {awvalid, wvalid}, 2'b11);
    #3 rst = 1;
    #1;
    chk("rst_mid_write", {awvalid, wvalid, rsp_valid, bready, cmd_ready}, 5'b0);
    exp_q.delete();
    tick(); tick();
    rst = 0;
    #1;
    chk("cmd_ready_post_rst", cmd_ready, 1'b1);
    cfg_aw = 0; cfg_w = 0;
    repeat (15) tick();
    chk("no_rsp_after_rst", 64'(n_rsp), 64'(base));

    // Reset while a read response is being held
    rsp_hold = 50; cfg_rdata = 32'hA5A50001; cfg_rresp = 2'b11;
    send_cmd(0, 4'h2, 32'h0, 4'h0, 2, 1'b0, acc1);
    n = 0;
    while (!rsp_valid && n < 50) begin tick(); n++; end
    chk("rsp_seen", rsp_valid, 1'b1);
    base = n_rsp;
    #3 rst = 1;
    #1;
    chk("rst_rsp_clear", {rsp_valid, rsp_write, rsp_resp, rsp_rdata}, '0);
    tick(); tick();
    rst = 0; rsp_hold = 0;
    repeat (10) tick();
    chk("no_rsp_after_rst2", 64'(n_rsp), 64'(base));

    // Randomized transactions
    for (int i = 0; i < 30; i++) begin
      ra = AW'($urandom);
      rdv = $urandom;
      rrd = $urandom;
      rs = SW'($urandom);
      run_txn(1'($urandom_range(0, 1)), ra, rdv, rs,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), rrd, int'($urandom_range(0, 3)));
    end

    repeat (5) tick();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
